// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter in front of a single-port memory.
// After reset the memory is swept to zero, one address per cycle; then
// requesters are granted one at a time, with reads answered one cycle later.
module mem_arbiter #(
  parameter int NumReq    = 2,
  parameter int ElemWidth = 8,
  parameter int AddrWidth = 8
) (
  input  logic                                clk_i,
  input  logic                                arst_ni,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq-1:0]                   req_we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0][ElemWidth-1:0]    req_wdata_i,
  output logic [NumReq-1:0]                   rsp_valid_o,
  output logic [ElemWidth-1:0]                rsp_data_o,
  output logic                                init_done_o
);

  localparam int Depth    = 2 ** AddrWidth;
  localparam int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   cnt_q, cnt_d;
  logic [IdxWidth-1:0]    last_grant_q;
  logic [NumReq-1:0]      rsp_valid_q;
  logic [ElemWidth-1:0]   rsp_data_q;

  logic [ElemWidth-1:0]   mem_q [Depth];

  logic [IdxWidth-1:0]    cand;
  logic [IdxWidth-1:0]    grant_idx;
  logic                   grant_found;
  logic [NumReq-1:0]      grant_oh;
  logic                   hs;
  logic                   rd_hs;
  logic                   sel_we;
  logic                   mem_we;
  logic [AddrWidth-1:0]   mem_addr;
  logic [ElemWidth-1:0]   mem_wdata;

  // Round-robin pick: first valid requester after the last one granted.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    cand        = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    grant_oh    = '0;
    for (int off = 1; off <= NumReq; off++) begin
      cand = IdxWidth'((int'(last_grant_q) + off) % NumReq);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    if (grant_found) grant_oh[grant_idx] = 1'b1;
  end

  assign hs          = (state_q == RUN) && grant_found;
  assign sel_we      = req_we_i[grant_idx];
  assign rd_hs       = hs && !sel_we;
  assign req_ready_o = hs ? grant_oh : '0;

  // Memory port steering: the clear sweep owns the port during INIT.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = req_addr_i[grant_idx];
    mem_wdata = req_wdata_i[grant_idx];
    if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_addr  = cnt_q;
      mem_wdata = '0;
    end else if (hs && sel_we) begin
      mem_we = 1'b1;
    end
  end

  // Storage array write port.
  // NOTE: the array has no reset; its contents are cleared by the INIT sweep.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
  end

  // Next-state logic: sweep counter runs in INIT, leaves on the last address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end
      RUN: ;
      default: state_d = INIT;
    endcase
  end

  // State, sweep counter and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (!arst_ni) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      last_grant_q <= IdxWidth'(NumReq - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hs) last_grant_q <= grant_idx;
    end
  end

  // Read response: one-cycle strobe and held data.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rd_hs ? grant_oh : '0;
      if (rd_hs) rsp_data_q <= mem_q[mem_addr];
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign init_done_o = (state_q == RUN);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (2 requesters,
// 8-bit data, 256-entry memory).
module tb_mem_arbiter;

  logic            clk_i = 1'b0;
  logic            arst_ni;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [1:0][7:0] req_addr;
  logic [1:0][7:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [7:0]      rsp_data;
  logic            init_done;

  int checks = 0;
  int errors = 0;
  int cyc;

  mem_arbiter #(.NumReq(2), .ElemWidth(8), .AddrWidth(8)) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .init_done_o (init_done)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req_valid = 2'b00;
    req_we    = 2'b00;
  endtask

  // Run the clear sweep; count cycles until init_done, checking no grants.
  task automatic wait_init(input string tag);
    cyc = 0;
    while (!init_done && cyc < 300) begin
      tick();
      cyc++;
      if (!init_done) check({tag, "_ready_in_init"}, req_ready, 2'b00);
      check({tag, "_rsp_in_init"}, rsp_valid, 2'b00);
    end
    check({tag, "_init_cycles"}, cyc, 256);
  endtask

  initial begin
    arst_ni   = 1'b0;
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    #2;
    check("rst_init_done", init_done, 1'b0);
    check("rst_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_data", rsp_data, 8'h00);
    repeat (3) tick();
    arst_ni = 1'b1;
    #1;
    check("init_low_after_release", init_done, 1'b0);
    wait_init("init1");

    // Read of a cleared address.
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 8'h10;
    #1 check("rd10_ready", req_ready, 2'b01);
    tick(); idle();
    check("rd10_rsp_valid", rsp_valid, 2'b01);
    check("rd10_rsp_data", rsp_data, 8'h00);
    tick();
    check("rd10_strobe_one_cycle", rsp_valid, 2'b00);

    // req1 writes, req0 reads the same address the next cycle.
    req_valid = 2'b10; req_we = 2'b10; req_addr[1] = 8'h33; req_wdata[1] = 8'h5A;
    #1 check("wr33_ready", req_ready, 2'b10);
    tick();
    check("wr33_no_rsp", rsp_valid, 2'b00);
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 8'h33;
    #1 check("rd33_ready", req_ready, 2'b01);
    tick(); idle();
    check("rd33_rsp_valid", rsp_valid, 2'b01);
    check("rd33_rsp_data", rsp_data, 8'h5A);

    // Write A5 to 0x44 from req1; rsp_data must hold across a write.
    req_valid = 2'b10; req_we = 2'b10; req_addr[1] = 8'h44; req_wdata[1] = 8'hA5;
    tick(); idle();
    check("wr44_data_held", rsp_data, 8'h5A);
    check("wr44_no_rsp", rsp_valid, 2'b00);

    // Both reading continuously: last grant was req1, so 0,1,0,1.
    req_valid = 2'b11; req_we = 2'b00; req_addr[0] = 8'h33; req_addr[1] = 8'h44;
    for (int k = 0; k < 4; k++) begin
      #1 check("alt_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check("alt_rsp_valid", rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("alt_rsp_data", rsp_data, (k % 2 == 0) ? 8'h5A : 8'hA5);
    end
    idle();
    tick();
    check("alt_drain", rsp_valid, 2'b00);

    // Only req1 for 3 cycles, then both: 1,1,1,0,1.
    req_valid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #1 check("solo1_ready", req_ready, 2'b10);
      tick();
      check("solo1_rsp_valid", rsp_valid, 2'b10);
    end
    req_valid = 2'b11;
    #1 check("both_after_solo_a", req_ready, 2'b01);
    tick();
    #1 check("both_after_solo_b", req_ready, 2'b10);
    tick();

    // Idle cycles leave the pointer alone: req0 still next.
    idle();
    #1 check("idle_no_grant", req_ready, 2'b00);
    tick(); tick();
    check("idle_no_rsp", rsp_valid, 2'b00);
    req_valid = 2'b11;
    #1 check("after_idle_ready", req_ready, 2'b01);
    tick(); idle();

    // Write FF to 0x00, read it back, then reset with a response pending.
    req_valid = 2'b01; req_we = 2'b01; req_addr[0] = 8'h00; req_wdata[0] = 8'hFF;
    tick();
    req_we = 2'b00;
    tick();
    check("rdff_rsp_data", rsp_data, 8'hFF);
    check("rdff_rsp_valid", rsp_valid, 2'b01);
    arst_ni   = 1'b0;
    req_valid = 2'b11;
    req_addr[1] = 8'h33;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 2'b00);
    check("mid_rst_rsp_data", rsp_data, 8'h00);
    check("mid_rst_init_done", init_done, 1'b0);
    check("mid_rst_ready", req_ready, 2'b00);
    tick(); tick();
    check("mid_rst_hold_ready", req_ready, 2'b00);
    check("mid_rst_hold_rsp", rsp_valid, 2'b00);
    arst_ni = 1'b1;
    wait_init("init2");

    // Pointer reset: req0 wins first; memory was cleared.
    #1 check("post_rst_ready", req_ready, 2'b01);
    tick(); idle();
    check("post_rst_rsp_valid", rsp_valid, 2'b01);
    check("post_rst_rsp_data", rsp_data, 8'h00);
    req_valid = 2'b10; req_addr[1] = 8'h33;
    tick(); idle();
    check("post_rst_5a_cleared", rsp_data, 8'h00);
    check("post_rst_rsp1_valid", rsp_valid, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requester ports (>=2).
REQ-002 SHALL have parameter ElemWidth, default 8, memory element width in bits.
REQ-003 SHALL have parameter AddrWidth, default 8, address width; Depth = 2**AddrWidth.
REQ-004 SHALL have port clk_i  input  1  global clock; all state updates on its rising edge.
REQ-005 SHALL have port arst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid_i  input  [NumReq]  per-requester request valid.
REQ-007 SHALL have port req_ready_o  output  [NumReq]  per-requester grant/accept.
REQ-008 SHALL have port req_we_i  input  [NumReq]  1 = write, 0 = read.
REQ-009 SHALL have port req_addr_i  input  [NumReq][AddrWidth]  request address.
REQ-010 SHALL have port req_wdata_i  input  [NumReq][ElemWidth]  write data.
REQ-011 SHALL have port rsp_valid_o  output  [NumReq]  one-cycle read-response strobe per requester.
REQ-012 SHALL have port rsp_data_o  output  [ElemWidth]  shared registered read data.
REQ-013 SHALL have port init_done_o  output  1  high once memory clear completes.

Function
REQ-014 SHALL contain one single-port memory of Depth x ElemWidth (write on clock edge, combinational read) as its only storage array.
REQ-015 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-016 In INIT SHALL write 0 to addresses 0..Depth-1, one per cycle ascending, via an AddrWidth-bit counter; req_ready_o all 0.
REQ-017 SHALL transition INIT->RUN on the edge writing address Depth-1; INIT lasts exactly Depth cycles; init_done_o high from first RUN cycle until reset.
REQ-018 In RUN SHALL grant at most one requester per cycle: req_ready_o[i] = 1 only for the selected valid requester, combinationally from req_valid_i.
REQ-019 Selection SHALL be round-robin: search starts at index (last_grant+1) mod NumReq; last_grant resets to NumReq-1 so requester 0 wins first.
REQ-020 last_grant SHALL update only on a handshake (valid & ready); idle cycles leave it unchanged.
REQ-021 Write handshake SHALL write req_wdata_i to req_addr_i at that edge; no response generated.
REQ-022 Read handshake SHALL capture mem[req_addr_i] into rsp_data_o at that edge and assert rsp_valid_o[i] for exactly the next cycle (latency 1).
REQ-023 rsp_data_o SHALL hold its value until the next read handshake; rsp_valid_o SHALL be one-hot or zero.
REQ-024 A read in cycle N+1 of an address written in cycle N SHALL return the new data.
REQ-025 Back-to-back reads from any requesters SHALL be accepted every cycle (throughput 1/cycle); responses are not back-pressurable.
REQ-026 Requesters SHALL hold valid and payload stable until ready; the block need not tolerate violations.
REQ-027 Requests with valid=0 SHALL never be granted; no valid requests -> no memory access.

Reset
REQ-028 arst_ni low SHALL immediately force: state INIT, counter 0, last_grant NumReq-1, req_ready_o 0, rsp_valid_o 0, rsp_data_o 0, init_done_o 0.
REQ-029 Reset asserted mid-INIT or mid-RUN SHALL abort any pending response and restart the full memory clear on release; memory contents before reset are not preserved.

Verification
REQ-030 Reset release, all valids 0 -> init_done_o low 256 cycles, high at cycle 256; req_ready_o 0 throughout INIT.
REQ-031 After init, req0 read addr 0x10 -> rsp_valid_o=2'b01 next cycle, rsp_data_o=0x00.
REQ-032 req1 write 0x5A to 0x33, next cycle req0 read 0x33 -> rsp_valid_o=2'b01, rsp_data_o=0x5A.
REQ-033 Both valid reading continuously -> grants alternate 0,1,0,1; rsp_valid_o alternates 2'b01,2'b10 one cycle later.
REQ-034 Only req1 valid for 3 cycles, then both -> req1 granted 3 times, then req0, then req1.
REQ-035 Write 0xFF to 0x00, assert arst_ni low mid-RUN for 2 cycles, rerun init, read 0x00 -> rsp_data_o=0x00; all outputs 0 during reset.
